// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an 8x8 single-port synchronous RAM; pop has priority over push.
// Optional sticky overflow/underflow flags are enabled by defining RAM_FIFO_ERR_EN.
module ram_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_acc,
  input  logic          pop,
  output logic          pop_acc,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [DW-1:0] ram_dataIn,
  output logic [AW-1:0] ram_Addr,
  output logic          ram_CS,
  output logic          ram_WE,
  input  logic [DW-1:0] ram_dataOut
`ifdef RAM_FIFO_ERR_EN
  ,
  output logic          overflow,
  output logic          underflow
`endif
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          rdValid_q;

  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign rd_valid = rdValid_q;
  assign rd_data  = ram_dataOut;

  // Single RAM port: an accepted pop owns the port, a push only gets it when no pop is accepted.
  always_comb begin
    pop_acc    = pop & ~empty & ~Rst;
    push_acc   = push & ~full & ~pop_acc & ~Rst;
    ram_CS     = 1'b0;
    ram_WE     = 1'b0;
    ram_Addr   = '0;
    ram_dataIn = '0;
    if (pop_acc) begin
      ram_CS   = 1'b1;
      ram_Addr = rdPtr_q;
    end else if (push_acc) begin
      ram_CS     = 1'b1;
      ram_WE     = 1'b1;
      ram_Addr   = wrPtr_q;
      ram_dataIn = push_data;
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_acc) begin
      wrPtr_d = wrPtr_q + AW'(1);
      count_d = count_q + (AW+1)'(1);
    end
    if (pop_acc) begin
      rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rdValid_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rdValid_q <= pop_acc;
    end
  end

`ifdef RAM_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Sticky until reset; a push against a full FIFO is not an error when a pop frees the slot.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (push & full & ~pop_acc);
      underflow_q <= underflow_q | (pop & empty);
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Table-driven bench for ram_fifo_ctrl with a behavioural 8x8 single-port RAM attached.
// Define RAM_FIFO_ERR_EN to also check the sticky overflow/underflow flags.
module tb_ram_fifo_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       push;
  logic [7:0] push_data;
  logic       push_acc;
  logic       pop;
  logic       pop_acc;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic [7:0] ram_dataIn;
  logic [2:0] ram_Addr;
  logic       ram_CS;
  logic       ram_WE;
  logic [7:0] ram_dataOut;
`ifdef RAM_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  ram_fifo_ctrl #(.DW(8), .AW(3), .DEPTH(8)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .push        (push),
    .push_data   (push_data),
    .push_acc    (push_acc),
    .pop         (pop),
    .pop_acc     (pop_acc),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .ram_dataIn  (ram_dataIn),
    .ram_Addr    (ram_Addr),
    .ram_CS      (ram_CS),
    .ram_WE      (ram_WE),
    .ram_dataOut (ram_dataOut)
`ifdef RAM_FIFO_ERR_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  always #5 Clk = ~Clk;

  // Behavioural RAM: registered read, output undefined when not selected.
  logic [7:0] mem [8];
  always @(posedge Clk) begin
    if (ram_CS) begin
      if (ram_WE) mem[ram_Addr] <= ram_dataIn;
      else        ram_dataOut   <= mem[ram_Addr];
    end else begin
      ram_dataOut <= 'x;
    end
  end

  typedef struct {
    logic       rst;
    logic       push;
    logic [7:0] data;
    logic       pop;
    logic       pushAcc;
    logic       popAcc;
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic       rdValid;
    logic [7:0] rdData;
    logic [3:0] count;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t vecs[$];
  int   vecCount  = 0;
  int   missCount = 0;

  function automatic vec_t mkVec(int rst, int psh, int data, int pp, int pushAcc, int popAcc,
                                 int cs, int we, int addr, int din, int rdValid, int rdData,
                                 int cnt, int fl, int em);
    vec_t v;
    v.rst = 1'(rst);      v.push = 1'(psh);       v.data = 8'(data);  v.pop = 1'(pp);
    v.pushAcc = 1'(pushAcc); v.popAcc = 1'(popAcc); v.cs = 1'(cs);     v.we = 1'(we);
    v.addr = 3'(addr);    v.din = 8'(din);        v.rdValid = 1'(rdValid);
    v.rdData = 8'(rdData); v.count = 4'(cnt);     v.full = 1'(fl);    v.empty = 1'(em);
    return v;
  endfunction

  task automatic addVec(int rst, int psh, int data, int pp, int pushAcc, int popAcc,
                        int cs, int we, int addr, int din, int rdValid, int rdData,
                        int cnt, int fl, int em);
    vecs.push_back(mkVec(rst, psh, data, pp, pushAcc, popAcc, cs, we, addr, din,
                         rdValid, rdData, cnt, fl, em));
  endtask

  task automatic applyStimulus(input vec_t v);
    Rst       = v.rst;
    push      = v.push;
    push_data = v.data;
    pop       = v.pop;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic ok;
    ok = (push_acc == v.pushAcc) && (pop_acc == v.popAcc) && (ram_CS == v.cs) &&
         (ram_WE == v.we) && (ram_Addr == v.addr) && (rd_valid == v.rdValid) &&
         (count == v.count) && (full == v.full) && (empty == v.empty);
    if (!(v.cs && !v.we) && ram_dataIn !== v.din) ok = 1'b0;
    if (v.rdValid && rd_data !== v.rdData) ok = 1'b0;
    vecCount++;
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL vec%0d: got pa=%b qa=%b cs=%b we=%b a=%0d din=%0d rv=%b rd=%0d cnt=%0d f=%b e=%b, exp pa=%b qa=%b cs=%b we=%b a=%0d din=%0d rv=%b rd=%0d cnt=%0d f=%b e=%b",
               idx, push_acc, pop_acc, ram_CS, ram_WE, ram_Addr, ram_dataIn, rd_valid, rd_data,
               count, full, empty, v.pushAcc, v.popAcc, v.cs, v.we, v.addr, v.din, v.rdValid,
               v.rdData, v.count, v.full, v.empty);
    end
  endtask

  task automatic runVec(input vec_t v, input int idx);
    applyStimulus(v);
    @(negedge Clk);
    checkOutput(v, idx);
    @(posedge Clk);
    #1;
  endtask

`ifdef RAM_FIFO_ERR_EN
  task automatic checkFlags(input int idx, input logic expOv, input logic expUn);
    vecCount++;
    if (overflow !== expOv || underflow !== expUn) begin
      missCount++;
      $display("[TB] FAIL flags%0d: got overflow=%b underflow=%b, exp overflow=%b underflow=%b",
               idx, overflow, underflow, expOv, expUn);
    end
  endtask
`endif

  initial begin
    //     rst psh dat pop  pa qa cs we adr din  rv rd  cnt f e
    // Reset holds everything off even with both requests raised.
    addVec(1, 1, 17, 1,   0, 0, 0, 0, 0, 0,    0, 0,  0, 0, 1);
    addVec(0, 0, 0, 0,    0, 0, 0, 0, 0, 0,    0, 0,  0, 0, 1);
    addVec(0, 0, 0, 1,    0, 0, 0, 0, 0, 0,    0, 0,  0, 0, 1);
    addVec(0, 0, 0, 0,    0, 0, 0, 0, 0, 0,    0, 0,  0, 0, 1);
    // Fill with 30..37, then a rejected 9th push.
    for (int i = 0; i < 8; i++)
      addVec(0, 1, 30+i, 0, 1, 0, 1, 1, i, 30+i, 0, 0, i, 0, (i == 0) ? 1 : 0);
    addVec(0, 1, 38, 0,   0, 0, 0, 0, 0, 0,    0, 0,  8, 1, 0);
    // Drain 8 back-to-back pops; data trails the address by one cycle.
    for (int j = 0; j < 8; j++)
      addVec(0, 0, 0, 1, 0, 1, 1, 0, j, 0, (j > 0) ? 1 : 0, 30+j-1, 8-j, (j == 0) ? 1 : 0, 0);
    addVec(0, 0, 0, 0,    0, 0, 0, 0, 0, 0,    1, 37, 0, 0, 1);
    // Advance both pointers to 5, then push 40..45 across the wrap.
    for (int i = 0; i < 5; i++)
      addVec(0, 1, 10+i, 0, 1, 0, 1, 1, i, 10+i, 0, 0, i, 0, (i == 0) ? 1 : 0);
    for (int j = 0; j < 5; j++)
      addVec(0, 0, 0, 1, 0, 1, 1, 0, j, 0, (j > 0) ? 1 : 0, 10+j-1, 5-j, 0, 0);
    for (int k = 0; k < 6; k++)
      addVec(0, 1, 40+k, 0, 1, 0, 1, 1, (5+k) % 8, 40+k, (k == 0) ? 1 : 0, 14, k, 0,
             (k == 0) ? 1 : 0);
    for (int j = 0; j < 6; j++)
      addVec(0, 0, 0, 1, 0, 1, 1, 0, (5+j) % 8, 0, (j > 0) ? 1 : 0, 40+j-1, 6-j, 0, 0);
    addVec(0, 0, 0, 0,    0, 0, 0, 0, 0, 0,    1, 45, 0, 0, 1);
    // Contention: pointers at 3; two entries, then push+pop held for 3 cycles.
    addVec(0, 1, 50, 0,   1, 0, 1, 1, 3, 50,   0, 0,  0, 0, 1);
    addVec(0, 1, 51, 0,   1, 0, 1, 1, 4, 51,   0, 0,  1, 0, 0);
    addVec(0, 1, 60, 1,   0, 1, 1, 0, 3, 0,    0, 0,  2, 0, 0);
    addVec(0, 1, 60, 1,   0, 1, 1, 0, 4, 0,    1, 50, 1, 0, 0);
    addVec(0, 1, 60, 1,   1, 0, 1, 1, 5, 60,   1, 51, 0, 0, 1);
    addVec(0, 0, 0, 0,    0, 0, 0, 0, 0, 0,    0, 0,  1, 0, 0);
    addVec(0, 0, 0, 1,    0, 1, 1, 0, 5, 0,    0, 0,  1, 0, 0);
    addVec(0, 0, 0, 0,    0, 0, 0, 0, 0, 0,    1, 60, 0, 0, 1);

    Rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    repeat (2) @(posedge Clk);
    #1;

    foreach (vecs[i]) runVec(vecs[i], i);

`ifdef RAM_FIFO_ERR_EN
    checkFlags(0, 1'b1, 1'b1);
`endif

    // Reset one cycle after an accepted pop discards the in-flight read.
    runVec(mkVec(0, 1, 65, 0, 1, 0, 1, 1, 6, 65, 0, 0,  0, 0, 1), 100);
    runVec(mkVec(0, 1, 66, 0, 1, 0, 1, 1, 7, 66, 0, 0,  1, 0, 0), 101);
    runVec(mkVec(0, 0, 0, 1,  0, 1, 1, 0, 6, 0,  0, 0,  2, 0, 0), 102);
    runVec(mkVec(1, 1, 67, 1, 0, 0, 0, 0, 0, 0,  1, 65, 1, 0, 0), 103);
    runVec(mkVec(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 1), 104);
`ifdef RAM_FIFO_ERR_EN
    checkFlags(1, 1'b0, 1'b0);
`endif
    runVec(mkVec(0, 1, 70, 0, 1, 0, 1, 1, 0, 70, 0, 0,  0, 0, 1), 105);
    runVec(mkVec(0, 0, 0, 1,  0, 1, 1, 0, 0, 0,  0, 0,  1, 0, 0), 106);
    runVec(mkVec(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 70, 0, 0, 1), 107);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of the 8x8 single-port synchronous RAM (dataIn/Addr/CS/WE/Clk in, registered dataOut).
- Converts push/pop requests into RAM write/read cycles and keeps the read/write pointers, occupancy count and full/empty flags.
- Returns read data with the RAM's one-cycle latency.
- Single RAM port: at most one RAM access per cycle, so pop has priority over push.

Parameters:
- DW, 8, data width; equals RAM word width.
- AW, 3, address width; equals RAM address width.
- DEPTH, 8, number of entries; must equal 2**AW.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- push  input  1  write request.
- push_data  input  DW  data to write.
- push_acc  output  1  combinational; push accepted this cycle.
- pop  input  1  read request.
- pop_acc  output  1  combinational; pop accepted this cycle.
- rd_data  output  DW  read data; valid only while rd_valid=1.
- rd_valid  output  1  registered; rd_data valid this cycle.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- count  output  AW+1  occupancy, 0..DEPTH.
- ram_dataIn  output  DW  to RAM dataIn.
- ram_Addr  output  AW  to RAM Addr.
- ram_CS  output  1  to RAM CS.
- ram_WE  output  1  to RAM WE.
- ram_dataOut  input  DW  from RAM dataOut.

Behaviour:
- One clock, Clk. Synchronous active-high reset, Rst.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, empty=1, full=0.
- RAM contents are not cleared by reset.
- While Rst=1:
  - ram_CS=0, ram_WE=0, push_acc=0, pop_acc=0.
  - Requests are ignored.
- pop_acc = pop & ~empty & ~Rst.
- push_acc = push & ~full & ~pop_acc & ~Rst. Pop always wins; a rejected push must be held by the producer.
- RAM drive is combinational, in the same cycle as the accept:
  - pop_acc: ram_CS=1, ram_WE=0, ram_Addr=rd_ptr.
  - push_acc: ram_CS=1, ram_WE=1, ram_Addr=wr_ptr, ram_dataIn=push_data.
  - Neither: ram_CS=0, ram_WE=0, ram_Addr=0, ram_dataIn=0.
- Pointer updates at the accepting edge:
  - On push_acc: wr_ptr += 1, wrapping modulo DEPTH (7 -> 0).
  - On pop_acc: rd_ptr += 1, same wrap.
- Count updates at the accepting edge:
  - count +1 on push_acc, -1 on pop_acc.
  - Both can never be accepted in the same cycle.
- Read latency is 1:
  - rd_valid is registered pop_acc.
  - rd_data = ram_dataOut, passed through combinationally.
  - Back-to-back pops give rd_valid on consecutive cycles.
- rd_data is don't-care (the RAM drives X when CS=0) whenever rd_valid=0. Consumers must qualify on rd_valid.
- full and empty are decoded combinationally from count. count never exceeds DEPTH or goes below 0.
- Push while full: rejected, no RAM access, no state change.
- Pop while empty: rejected; rd_valid=0 next cycle.
- Push and pop both requested while empty: pop is rejected, so push is accepted.
- Reset asserted the cycle after a pop_acc: rd_valid=0 on the following cycle. The in-flight read is discarded.

Optional Feature:
- Macro: RAM_FIFO_ERR_EN.
- Defined:
  - Adds outputs overflow and underflow, 1 bit each, sticky, reset to 0.
  - overflow sets on the edge where push=1 & full=1 & ~pop_acc.
  - underflow sets on the edge where pop=1 & empty=1.
  - Both are cleared only by Rst.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Required: count=0, empty=1, full=0, rd_valid=0, ram_CS=0.
  - pop=1 for 1 cycle -> pop_acc=0, rd_valid stays 0.
- Push 30..37, one per cycle:
  - Required: ram_WE=1 with Addr 0..7.
  - After the 8th push: count=8, full=1.
  - A 9th push (38) -> push_acc=0, count stays 8.
  - With the macro: overflow=1.
- Pop 8 consecutive cycles from full:
  - Required: rd_valid=1 on the cycles 1..8 after the first pop, rd_data=30..37 in order.
  - Then empty=1, count=0.
- Wrap-around:
  - Push 5, pop 5, then push 40..45 (6 entries, wr_ptr wraps 5->7->0->2).
  - Pop 6 -> rd_data=40..45, Addr sequence 5,6,7,0,1,2.
- Contention:
  - count=2 (entries 50, 51); push=1 (data 60) and pop=1 held 3 cycles.
  - Required: pops accepted while not empty (rd_data 50, 51); push_acc=0 for those 2 cycles.
  - 3rd cycle: empty, so push_acc=1; count ends at 1.
- Reset mid-read:
  - Pop accepted at cycle N, Rst=1 at cycle N+1 -> rd_valid=0 at N+2, count=0, empty=1.
  - Subsequent push 70 then pop -> rd_data=70.
